// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, IF/ID register, run-control FSM, optional perf counters (FETCH_PERF_CNT_EN)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] END_ADDR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        id_jump,
  input  logic        id_beq,
  input  logic        id_bne,
  input  logic        id_equal,
  input  logic [31:0] id_br_target,
  input  logic [31:0] id_j_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [1:0]  state,
  output logic [31:0] cnt_fetch,
  output logic [31:0] cnt_flush,
  output logic [31:0] cnt_stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } fetchState_t;

  fetchState_t curState;
  fetchState_t nextState;

  logic [31:0] pcNext;
  logic [31:0] instrNext;
  logic [31:0] pc4Next;
  logic        validNext;
  logic        fetchLoad;
  logic        flushEv;
  logic        stallEv;

  logic        taken;
  logic [31:0] target;
  logic [31:0] pcPlus4;

  assign imem_addr = pc;
  assign state     = curState;
  assign pcPlus4   = pc + 32'd4;

  // Redirect decision for the instruction in ID; jump wins over branch, targets word-aligned
  always_comb begin
    taken  = id_jump | (id_beq & id_equal) | (id_bne & ~id_equal);
    target = (id_jump ? id_j_target : id_br_target) & 32'hFFFF_FFFC;
  end

  // Next-state and datapath selection: stall > taken > halt check > normal fetch
  always_comb begin
    nextState = curState;
    pcNext    = pc;
    instrNext = if_id_instr;
    pc4Next   = if_id_pc4;
    validNext = if_id_valid;
    fetchLoad = 1'b0;
    flushEv   = 1'b0;
    stallEv   = 1'b0;
    case (curState)
      IDLE: begin
        pcNext    = RESET_PC;
        instrNext = 32'h0;
        pc4Next   = 32'h0;
        validNext = 1'b0;
        if (start) nextState = RUN;
      end
      RUN, HALTED: begin
        if (stall) begin
          stallEv = 1'b1;
        end else if (taken) begin
          flushEv   = 1'b1;
          pcNext    = target;
          instrNext = 32'h0;
          pc4Next   = 32'h0;
          validNext = 1'b0;
          nextState = RUN;
        end else if (curState == RUN && pc < END_ADDR) begin
          fetchLoad = 1'b1;
          instrNext = imem_rdata;
          pc4Next   = pcPlus4;
          validNext = 1'b1;
          pcNext    = pcPlus4;
        end else begin
          // Past end of program, or draining while halted: insert bubbles, hold pc
          instrNext = 32'h0;
          pc4Next   = 32'h0;
          validNext = 1'b0;
          nextState = HALTED;
        end
      end
      default: begin
        nextState = IDLE;
        pcNext    = RESET_PC;
        instrNext = 32'h0;
        pc4Next   = 32'h0;
        validNext = 1'b0;
      end
    endcase
  end

  // State, PC and IF/ID registers
  always_ff @(posedge clk) begin
    if (reset) begin
      curState    <= IDLE;
      pc          <= RESET_PC;
      if_id_instr <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
    end else begin
      curState    <= nextState;
      pc          <= pcNext;
      if_id_instr <= instrNext;
      if_id_pc4   <= pc4Next;
      if_id_valid <= validNext;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCnt;
  logic [31:0] flushCnt;
  logic [31:0] stallCnt;

  // Performance counters, free-running with natural 32-bit wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchCnt <= 32'h0;
      flushCnt <= 32'h0;
      stallCnt <= 32'h0;
    end else begin
      if (fetchLoad) fetchCnt <= fetchCnt + 32'd1;
      if (flushEv)   flushCnt <= flushCnt + 32'd1;
      if (stallEv)   stallCnt <= stallCnt + 32'd1;
    end
  end

  assign cnt_fetch = fetchCnt;
  assign cnt_flush = flushCnt;
  assign cnt_stall = stallCnt;
`else
  logic unusedEvents;
  assign unusedEvents = fetchLoad ^ flushEv ^ stallEv;
  assign cnt_fetch = 32'h0;
  assign cnt_flush = 32'h0;
  assign cnt_stall = 32'h0;
`endif

endmodule
